aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: NR, 14, number of AES rounds (AES-256); the round counter spans 0..NR.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 in_valid_i / in_ready_o  input / output  1 / 1  plaintext-block handshake.
REQ-005 in_data_i  input  128  block to be encrypted.
REQ-006 rk_req_o / rk_valid_i  output / input  1 / 1  round-key request handshake to key expansion.
REQ-007 rk_idx_o  output  4  index of the requested round key (equals current round).
REQ-008 round_state_o  output  128  current state register, driven to the external round datapath.
REQ-009 round_op_o  output  2  datapath op: 00 = AddRoundKey only; 01 = full round; 10 = final round, MixColumns bypassed.
REQ-010 round_result_i  input  128  combinational datapath result for the current state, op and key.
REQ-011 out_valid_o / out_ready_i  output / input  1 / 1  ciphertext handshake.
REQ-012 out_data_o  output  128  ciphertext, equal to the state register while out_valid_o is high.
REQ-013 busy_o  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ROUND and DONE.
REQ-015 IDLE: in_ready_o=1; on in_valid_i&in_ready_o the block SHALL latch in_data_i into state, clear round to 0 and go to ROUND.
REQ-016 ROUND: rk_req_o=1 and rk_idx_o=round; on rk_valid_i the block SHALL load round_result_i into state.
REQ-017 ROUND with rk_valid_i and round<NR: round SHALL increment; with round==NR: go to DONE.
REQ-018 ROUND with rk_valid_i low: the block SHALL hold state and round with no limit.
REQ-019 round_op_o SHALL be 00 for round 0, 01 for rounds 1..NR-1, 10 for round NR, and 00 outside ROUND.
REQ-020 DONE: out_valid_o=1; on out_ready_i the block SHALL go to IDLE; out_data_o SHALL stay stable while out_ready_i is low.
REQ-021 in_ready_o SHALL be 0 outside IDLE; in_valid_i SHALL then be ignored.
REQ-022 With rk_valid_i tied high, latency from input acceptance to out_valid_o SHALL be NR+2 cycles.
REQ-023 A new block SHALL be acceptable no earlier than one cycle after the output handshake.
REQ-024 The round counter SHALL never exceed NR and SHALL never wrap.

Reset
REQ-025 On rst_i the block SHALL enter IDLE with state=0 and round=0.
REQ-026 Output values under reset SHALL be: in_ready_o=1; rk_req_o=0; out_valid_o=0; busy_o=0; round_op_o=00; rk_idx_o=0.
REQ-027 Reset asserted mid-operation SHALL discard the block in flight and produce no output.

Configuration
REQ-028 Macro AES_CTRL_ABORT_EN SHALL add input port abort_i (1 bit).
REQ-029 With the macro defined, abort_i SHALL force the next state to IDLE from any state, clear state and round, and suppress any pending output; abort_i SHALL win over a simultaneous input, key or output handshake.
REQ-030 Without the macro, port abort_i SHALL be absent and the block SHALL have no abort logic.

Structure
REQ-031 Package aes_pkg SHALL hold NR, the round_op encoding constants and the FSM state enum.
REQ-032 The block SHALL contain no sub-module; the counter and FSM SHALL be inline, and SubBytes/ShiftRows/MixColumns/AddRoundKey SHALL remain external.

Verification
REQ-033 Single block: the bench SHALL cover FIPS-197 AES-256 vector (key 000102..1f, plaintext 00112233..ff) with rk_valid_i=1 -> ciphertext 8ea2b7ca516745bfeafc49904b496089 with out_valid_o at cycle 16.
REQ-034 Op sequence: the bench SHALL check round_op_o = 00, then 01 x13, then 10, with rk_idx_o counting 0..14.
REQ-035 Key stalls: rk_valid_i low for 3 cycles at rounds 0, 7 and 14 -> same ciphertext, out_valid_o at cycle 25.
REQ-036 Backpressure: out_ready_i held low for 10 cycles -> out_data_o stable and in_ready_o=0 throughout; a block offered meanwhile SHALL be accepted only after return to IDLE.
REQ-037 Reset at round 5 -> next cycle busy_o=0 and in_ready_o=1; no out_valid_o pulse.
REQ-038 With AES_CTRL_ABORT_EN, abort_i in the same cycle as out_ready_i in DONE -> IDLE next cycle and no output handshake counted.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and FSM state type for the AES round controller.
package aes_pkg;

  localparam int NR = 14;

  localparam logic [1:0] OP_ADDKEY = 2'b00;
  localparam logic [1:0] OP_FULL   = 2'b01;
  localparam logic [1:0] OP_FINAL  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } ctrlState_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: owns the state register and round counter, drives an external round datapath.
// Optional build macro AES_CTRL_ABORT_EN adds an abort_i port that returns the block to IDLE.
module aes_round_ctrl #(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk_i,
  input  logic         rst_i,
`ifdef AES_CTRL_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  output logic         rk_req_o,
  input  logic         rk_valid_i,
  output logic [3:0]   rk_idx_o,
  output logic [127:0] round_state_o,
  output logic [1:0]   round_op_o,
  input  logic [127:0] round_result_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         busy_o
);
  import aes_pkg::*;

  localparam logic [3:0] RoundLast = 4'(NR);

  ctrlState_e   fsmState_q, fsmState_d;
  logic [127:0] data_q, data_d;
  logic [3:0]   round_q, round_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsmState_q <= IDLE;
      data_q     <= '0;
      round_q    <= '0;
    end else begin
      fsmState_q <= fsmState_d;
      data_q     <= data_d;
      round_q    <= round_d;
    end
  end

  // The counter stops at the last round and the FSM leaves ROUND there, so it can never wrap.
  always_comb begin
    fsmState_d = fsmState_q;
    data_d     = data_q;
    round_d    = round_q;
    unique case (fsmState_q)
      IDLE: begin
        if (in_valid_i) begin
          data_d     = in_data_i;
          round_d    = '0;
          fsmState_d = ROUND;
        end
      end
      ROUND: begin
        if (rk_valid_i) begin
          data_d = round_result_i;
          if (round_q == RoundLast) begin
            fsmState_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (out_ready_i) begin
          fsmState_d = IDLE;
          round_d    = '0;
        end
      end
      default: fsmState_d = IDLE;
    endcase
`ifdef AES_CTRL_ABORT_EN
    if (abort_i) begin
      fsmState_d = IDLE;
      data_d     = '0;
      round_d    = '0;
    end
`endif
  end

  always_comb begin
    in_ready_o  = 1'b0;
    rk_req_o    = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    round_op_o  = OP_ADDKEY;
    unique case (fsmState_q)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
      end
      ROUND: begin
        rk_req_o = 1'b1;
        if (round_q == 4'd0) begin
          round_op_o = OP_ADDKEY;
        end else if (round_q == RoundLast) begin
          round_op_o = OP_FINAL;
        end else begin
          round_op_o = OP_FULL;
        end
      end
      DONE: out_valid_o = 1'b1;
      default: busy_o = 1'b1;
    endcase
`ifdef AES_CTRL_ABORT_EN
    // Masking the handshakes keeps an aborted cycle from looking like an accepted block or output.
    if (abort_i) begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
    end
`endif
  end

  assign rk_idx_o      = round_q;
  assign round_state_o = data_q;
  assign out_data_o    = data_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with a behavioural AES-256 round datapath and key schedule.
// Define AES_CTRL_ABORT_EN to also exercise the abort port.
module tb_aes_round_ctrl;

  localparam int NR = 14;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct {
    int           id;
    logic [127:0] plain;
    logic [15:0]  stallMask;
    int           stallLen;
    int           outDelay;
    logic [127:0] cipher;
    int           latency;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         abort = 1'b0;
  logic         inValid = 1'b0;
  logic [127:0] inData = '0;
  logic         rkValid = 1'b0;
  logic [127:0] roundResult = '0;
  logic         outReady = 1'b0;

  logic         in_ready_o, rk_req_o, out_valid_o, busy_o;
  logic [3:0]   rk_idx_o;
  logic [127:0] round_state_o, out_data_o;
  logic [1:0]   round_op_o;

  int checkCount = 0;
  int passCount = 0;
  int outHandshakes = 0;

  logic [7:0]   sbox [0:255];
  logic [127:0] rk [0:14];
  vec_t         vecs [4];

  aes_round_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
`ifdef AES_CTRL_ABORT_EN
    .abort_i        (abort),
`endif
    .in_valid_i     (inValid),
    .in_ready_o     (in_ready_o),
    .in_data_i      (inData),
    .rk_req_o       (rk_req_o),
    .rk_valid_i     (rkValid),
    .rk_idx_o       (rk_idx_o),
    .round_state_o  (round_state_o),
    .round_op_o     (round_op_o),
    .round_result_i (roundResult),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (outReady),
    .out_data_o     (out_data_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid_o && outReady) outHandshakes++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic buildTables();
    logic [7:0]  inv, b;
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int i = 0; i < 8; i++) w[i] = KEY[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end else if (i % 8 == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int k = 0; k < 15; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // Behavioural round datapath: op 00 = AddRoundKey, 01 = full round, 10 = final round.
  function automatic logic [127:0] dpModel(input logic [127:0] s, input logic [1:0] op, input logic [3:0] idx);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    if (op != 2'b00) begin
      for (int i = 0; i < 16; i++) a[i] = sbox[a[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
      for (int i = 0; i < 16; i++) a[i] = b[i];
      if (op == 2'b01) begin
        for (int c = 0; c < 4; c++) begin
          b[4*c]   = xtime(a[4*c]) ^ xtime(a[4*c+1]) ^ a[4*c+1] ^ a[4*c+2] ^ a[4*c+3];
          b[4*c+1] = a[4*c] ^ xtime(a[4*c+1]) ^ xtime(a[4*c+2]) ^ a[4*c+2] ^ a[4*c+3];
          b[4*c+2] = a[4*c] ^ a[4*c+1] ^ xtime(a[4*c+2]) ^ xtime(a[4*c+3]) ^ a[4*c+3];
          b[4*c+3] = xtime(a[4*c]) ^ a[4*c] ^ a[4*c+1] ^ a[4*c+2] ^ xtime(a[4*c+3]);
        end
        for (int i = 0; i < 16; i++) a[i] = b[i];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = a[i];
    return res ^ ((idx <= 4'd14) ? rk[idx] : 128'h0);
  endfunction

  function automatic logic [1:0] expOp(input int idx);
    if (idx == 0) return 2'b00;
    if (idx == NR) return 2'b10;
    return 2'b01;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    roundResult = dpModel(round_state_o, round_op_o, rk_idx_o);
  endtask

  // Walks the ROUND state, stalling the key handshake for stallLen cycles at each round set in mask.
  task automatic runRounds(input logic [15:0] mask, input int stallLen, input int stopIdx, inout int cyc);
    int           expIdx;
    int           stallLeft;
    int           guard;
    logic         stalled;
    logic [127:0] held;
    expIdx    = 0;
    stallLeft = mask[0] ? stallLen : 0;
    guard     = 0;
    stalled   = 1'b0;
    held      = '0;
    while (!out_valid_o && expIdx != stopIdx && guard < 100) begin
      checkOutput("rkReq", 128'(rk_req_o), 128'(1));
      checkOutput("rkIdx", 128'(rk_idx_o), 128'(expIdx));
      checkOutput("roundOp", 128'(round_op_o), 128'(expOp(expIdx)));
      checkOutput("roundReadyBusy", 128'({in_ready_o, busy_o}), 128'(2'b01));
      if (stalled) checkOutput("stallHold", round_state_o, held);
      held = round_state_o;
      if (stallLeft > 0) begin
        rkValid = 1'b0;
        stallLeft--;
        stalled = 1'b1;
      end else begin
        rkValid = 1'b1;
        stalled = 1'b0;
      end
      tick();
      cyc++;
      guard++;
      if (!stalled) begin
        expIdx++;
        stallLeft = (expIdx < 16 && mask[expIdx]) ? stallLen : 0;
      end
    end
    rkValid = 1'b0;
    checkOutput("roundGuard", 128'(guard < 100), 128'(1));
  endtask

  task automatic applyStimulus(input vec_t v);
    int cyc;
    checkOutput("idleState", 128'({in_ready_o, busy_o, out_valid_o}), 128'(3'b100));
    inValid = 1'b1;
    inData  = v.plain;
    tick();
    inValid = 1'b0;
    cyc = 1;
    checkOutput("latched", round_state_o, v.plain);
    runRounds(v.stallMask, v.stallLen, 99, cyc);
    checkOutput("latency", 128'(cyc), 128'(v.latency));
    checkOutput("outValid", 128'(out_valid_o), 128'(1));
    checkOutput("cipher", out_data_o, v.cipher);
    repeat (v.outDelay) begin
      tick();
      checkOutput("holdData", out_data_o, v.cipher);
      checkOutput("holdValid", 128'({out_valid_o, in_ready_o}), 128'(2'b10));
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput("backToIdle", 128'({busy_o, in_ready_o, out_valid_o}), 128'(3'b010));
  endtask

  initial begin
    int cyc;
    int hsBefore;
    logic sawValid;

    vecs[0] = '{0, PT, 16'h0000, 0, 0, CT, 16};
    vecs[1] = '{1, PT, 16'h4081, 3, 2, CT, 25};
    vecs[2] = '{2, PT, 16'h0008, 5, 0, CT, 21};
    vecs[3] = '{3, PT, 16'h4000, 1, 1, CT, 17};

    buildTables();
    #1;
    checkOutput("rstFlags", 128'({in_ready_o, rk_req_o, out_valid_o, busy_o}), 128'(4'b1000));
    checkOutput("rstOpIdx", 128'({round_op_o, rk_idx_o}), 128'(6'b000000));
    checkOutput("rstState", round_state_o, 128'h0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      $display("[TB] vector %0d", vecs[i].id);
      applyStimulus(vecs[i]);
    end
    checkOutput("handshakes", 128'(outHandshakes), 128'(4));

    // Backpressure with a competing block offered while the result waits.
    inValid = 1'b1;
    inData  = PT;
    tick();
    inValid = 1'b0;
    cyc = 1;
    runRounds(16'h0000, 0, 99, cyc);
    inValid = 1'b1;
    inData  = PT;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bpData", out_data_o, CT);
      checkOutput("bpFlags", 128'({out_valid_o, in_ready_o, busy_o}), 128'(3'b101));
      tick();
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput("bpIdle", 128'({busy_o, in_ready_o}), 128'(2'b01));
    checkOutput("bpNotLatched", round_state_o, CT);
    tick();
    inValid = 1'b0;
    checkOutput("bpAccepted", 128'({busy_o, rk_req_o, in_ready_o}), 128'(3'b110));
    checkOutput("bpNewBlock", round_state_o, PT);
    checkOutput("bpHandshakes", 128'(outHandshakes), 128'(5));

    // Reset in the middle of round 5 discards the block.
    cyc = 1;
    runRounds(16'h0000, 0, 5, cyc);
    checkOutput("atRound5", 128'(rk_idx_o), 128'(5));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstFlags", 128'({in_ready_o, rk_req_o, out_valid_o, busy_o}), 128'(4'b1000));
    checkOutput("midRstOpIdx", 128'({round_op_o, rk_idx_o}), 128'(6'b000000));
    checkOutput("midRstState", round_state_o, 128'h0);
    tick();
    rst = 1'b0;
    rkValid = 1'b1;
    sawValid = 1'b0;
    hsBefore = outHandshakes;
    repeat (20) begin
      tick();
      sawValid = sawValid | out_valid_o;
    end
    rkValid = 1'b0;
    checkOutput("noOutAfterRst", 128'(sawValid), 128'(0));
    checkOutput("rstHandshakes", 128'(outHandshakes), 128'(hsBefore));
    checkOutput("idleAfterRst", 128'({busy_o, in_ready_o}), 128'(2'b01));

`ifdef AES_CTRL_ABORT_EN
    // Abort coinciding with the output handshake must win.
    inValid = 1'b1;
    inData  = PT;
    tick();
    inValid = 1'b0;
    cyc = 1;
    runRounds(16'h0000, 0, 99, cyc);
    checkOutput("abortPreDone", 128'(out_valid_o), 128'(1));
    hsBefore = outHandshakes;
    abort    = 1'b1;
    outReady = 1'b1;
    #1;
    checkOutput("abortMasksValid", 128'(out_valid_o), 128'(0));
    tick();
    abort    = 1'b0;
    outReady = 1'b0;
    checkOutput("abortIdle", 128'({busy_o, in_ready_o, out_valid_o}), 128'(3'b010));
    checkOutput("abortCleared", round_state_o, 128'h0);
    checkOutput("abortHandshakes", 128'(outHandshakes), 128'(hsBefore));
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
